pfumx_rr_arb: RTL and testbench
===============================

Name: pfumx_rr_arb

Overview:
- Two-requester round-robin arbiter that shares one 2:1 PFU mux datapath (select input C0; C0=1 passes the A leg, C0=0 passes the B leg) between requesters A and B.
- Sequences grants with burst locking and an optional hold limit, drives the mux select, and registers the selected data with a valid strobe.
- Sits in front of PFUMX-based wide mux trees wherever two sources share one output path.

Parameters:
- WIDTH, 8, data width of DA, DB and Z.
- MAXHOLD, 16, maximum beats per grant before forced release when the other side is requesting; 0 disables the limit.
- HOLDW, 5, beat-counter width; must satisfy 2**HOLDW > MAXHOLD.

Ports:
- CK  input  1  clock, rising edge.
- CD  input  1  asynchronous active-high clear.
- REQA  input  1  requester A wants the path.
- REQB  input  1  requester B wants the path.
- LASTA  input  1  final beat of A's burst; sampled only on an A beat.
- LASTB  input  1  final beat of B's burst; sampled only on a B beat.
- DA  input  WIDTH  A data (mux A leg).
- DB  input  WIDTH  B data (mux B leg).
- GNTA  output  1  A owns the path, registered.
- GNTB  output  1  B owns the path, registered.
- SEL  output  1  mux select (C0); 1 selects A, registered.
- Z  output  WIDTH  registered selected data.
- ZV  output  1  Z valid, one cycle per beat.

Behaviour:
- Clock and reset: one clock CK; CD is asynchronous, active-high. CD=1 forces state IDLE, GNTA=0, GNTB=0, SEL=0, Z=0, ZV=0, beat count=0, priority pointer=A. CD is effective immediately, mid-burst included; the first grant after release needs a registered arbitration cycle.
- States: IDLE, OWN_A, OWN_B. GNTA=1 only in OWN_A; GNTB=1 only in OWN_B. Never both.
- Arbitration from IDLE:
  - REQA alone -> OWN_A next cycle.
  - REQB alone -> OWN_B next cycle.
  - Both -> owner is the priority pointer.
  - Grant latency is 1 cycle from request sampled.
- Beat: cycle with REQx=1 and GNTx=1. Each beat increments the beat count, saturating at 2**HOLDW-1. The next cycle, Z = DA (SEL=1) or DB (SEL=0) captured on that beat, and ZV=1. Z holds its value when there is no beat; ZV=0 then.
- Release from OWN_x when any of these holds in the current cycle:
  - REQx=0.
  - A beat with LASTx=1.
  - MAXHOLD!=0, the beat count after this beat equals MAXHOLD, and the other requester's REQ=1.
- On release:
  - Priority pointer moves to the other requester.
  - Beat count clears.
  - If the other REQ=1 in the same cycle, go directly to OWN_other (no IDLE bubble); GNT swaps in one cycle, never both high. Otherwise go to IDLE.
- Hold limit: when the hold limit is hit but the other side is idle, the grant is kept and the counter stays saturated at MAXHOLD. Release then happens on the first cycle the other REQ is seen.
- SEL: set to 1 on entering OWN_A, 0 on entering OWN_B, and held at its last value in IDLE. The last beat's data path stays stable.
- Simultaneous events: LASTx and hold-limit release on the same beat count as one release; the pointer moves once.
- Requests are level-sensitive. A requester deasserting REQ mid-burst forfeits the grant; no ZV is produced for that cycle.

Test Plan:
- Reset and single requester: CD pulse, then REQA=1 with DA=8'h11,8'h22,8'h33 and LASTA on the third beat -> GNTA rises at cycle 1; SEL=1; ZV on cycles 2-4 with Z=11,22,33; GNTA=0 after the third beat; pointer=B.
- Simultaneous first request: REQA=REQB=1 from reset -> A granted first. After A's LAST, GNTB=1 the very next cycle with no idle cycle, SEL=0, and Z carries DB.
- Hold limit: MAXHOLD=4, REQA held with no LASTA, REQB=1 -> exactly 4 A beats (4 ZV), then GNTB.
- Hold limit with idle B: MAXHOLD=4, REQA held, REQB low for 10 cycles then high -> A keeps the grant through 10+ beats; GNTB follows one cycle after REQB rises.
- Mid-burst abandon and async clear: REQA drops mid-burst -> IDLE, ZV=0, Z holds its last value. Then assert CD asynchronously while in OWN_B -> GNTB, ZV and SEL go 0 without a clock edge.
- Fairness: REQA and REQB both held with single-beat bursts (LAST=1) -> grants alternate A,B,A,B; SEL toggles every beat; ZV is continuous.

Source files
------------

// File: rtl/pfumx_rr_arb.sv
// Two-requester round-robin arbiter in front of a 2:1 PFU mux (C0=1 passes A).
// Burst locking with an optional hold limit and a registered output stage.
module pfumx_rr_arb #(
    parameter int WIDTH   = 8,
    parameter int MAXHOLD = 16,
    parameter int HOLDW   = 5
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             REQA,
    input  logic             REQB,
    input  logic             LASTA,
    input  logic             LASTB,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    output logic             GNTA,
    output logic             GNTB,
    output logic             SEL,
    output logic [WIDTH-1:0] Z,
    output logic             ZV
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [HOLDW-1:0] CNT_MAX  = {HOLDW{1'b1}};
    localparam logic [HOLDW-1:0] HOLD_LIM = HOLDW'(MAXHOLD);
    localparam logic             HOLD_EN  = (MAXHOLD != 0);

    // Beat count after one more beat; parks at the hold limit so an idle peer
    // can still trigger release on the first cycle it asks.
    function automatic logic [HOLDW-1:0] cnt_after(input logic [HOLDW-1:0] c);
        if (HOLD_EN && (c >= HOLD_LIM)) begin
            return HOLD_LIM;
        end else if (c == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return c + HOLDW'(1);
        end
    endfunction

    state_t           state_r, state_s;
    logic             ptr_r, ptr_s;       // 1: A has priority
    logic [HOLDW-1:0] cnt_r, cnt_s, cnt_nx_s;
    logic             sel_r;
    logic [WIDTH-1:0] z_r;
    logic             zv_r;
    logic             own_req_s, oth_req_s, own_last_s, beat_s, rel_s;

    // State, pointer, beat counter and registered datapath
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_r <= IDLE;
            ptr_r   <= 1'b1;
            cnt_r   <= {HOLDW{1'b0}};
            sel_r   <= 1'b0;
            z_r     <= {WIDTH{1'b0}};
            zv_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            if (state_s == OWN_A) begin
                sel_r <= 1'b1;
            end else if (state_s == OWN_B) begin
                sel_r <= 1'b0;
            end else begin
                sel_r <= sel_r;
            end
            if (beat_s) begin
                z_r <= sel_r ? DA : DB;
            end else begin
                z_r <= z_r;
            end
            zv_r <= beat_s;
        end
    end

    // Next-state: arbitration from IDLE, release and direct handover when owned
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        cnt_s      = cnt_r;
        own_req_s  = 1'b0;
        oth_req_s  = 1'b0;
        own_last_s = 1'b0;
        beat_s     = 1'b0;
        rel_s      = 1'b0;
        cnt_nx_s   = cnt_after(cnt_r);
        case (state_r)
            OWN_A: begin
                own_req_s  = REQA;
                oth_req_s  = REQB;
                own_last_s = LASTA;
            end
            OWN_B: begin
                own_req_s  = REQB;
                oth_req_s  = REQA;
                own_last_s = LASTB;
            end
            default: begin
                own_req_s  = 1'b0;
                oth_req_s  = 1'b0;
                own_last_s = 1'b0;
            end
        endcase

        if (state_r == IDLE) begin
            if (REQA && (!REQB || ptr_r)) begin
                state_s = OWN_A;
            end else if (REQB) begin
                state_s = OWN_B;
            end else begin
                state_s = IDLE;
            end
        end else if ((state_r == OWN_A) || (state_r == OWN_B)) begin
            beat_s = own_req_s;
            rel_s  = !own_req_s || own_last_s ||
                     (HOLD_EN && (cnt_nx_s == HOLD_LIM) && oth_req_s);
            if (rel_s) begin
                ptr_s = (state_r == OWN_B);
                cnt_s = {HOLDW{1'b0}};
                if (oth_req_s) begin
                    state_s = (state_r == OWN_A) ? OWN_B : OWN_A;
                end else begin
                    state_s = IDLE;
                end
            end else begin
                cnt_s = cnt_nx_s;
            end
        end else begin
            state_s = IDLE;
        end
    end

    // Outputs: grants decode the state register directly
    always_comb begin
        GNTA = (state_r == OWN_A);
        GNTB = (state_r == OWN_B);
        SEL  = sel_r;
        Z    = z_r;
        ZV   = zv_r;
    end

endmodule

// File: tb/tb_pfumx_rr_arb.sv
// Directed vector bench for pfumx_rr_arb with MAXHOLD=4.
module tb_pfumx_rr_arb;

    logic       CK = 1'b0;
    logic       CD, REQA, REQB, LASTA, LASTB;
    logic [7:0] DA, DB, Z;
    logic       GNTA, GNTB, SEL, ZV;

    int n_cmp = 0;
    int n_err = 0;

    pfumx_rr_arb #(.WIDTH(8), .MAXHOLD(4), .HOLDW(3)) dut (
        .CK(CK), .CD(CD), .REQA(REQA), .REQB(REQB), .LASTA(LASTA), .LASTB(LASTB),
        .DA(DA), .DB(DB), .GNTA(GNTA), .GNTB(GNTB), .SEL(SEL), .Z(Z), .ZV(ZV)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic       ra, rb, la, lb;
        logic [7:0] da, db;
        logic       ga, gb, sel;
        logic [7:0] z;
        logic       zv;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic ra, rb, la, lb, input logic [7:0] da, db,
                                input logic ga, gb, sel, input logic [7:0] z, input logic zv);
        vec_t v;
        v.ra = ra; v.rb = rb; v.la = la; v.lb = lb; v.da = da; v.db = db;
        v.ga = ga; v.gb = gb; v.sel = sel; v.z = z; v.zv = zv;
        return v;
    endfunction

    task automatic drive(input logic ra, rb, la, lb, input logic [7:0] da, db);
        REQA = ra; REQB = rb; LASTA = la; LASTB = lb; DA = da; DB = db;
    endtask

    task automatic chk(input string nm, input logic ga, gb, sel, input logic [7:0] z, input logic zv);
        n_cmp++;
        if ({GNTA, GNTB, SEL, Z, ZV} !== {ga, gb, sel, z, zv}) begin
            n_err++;
            $display("FAIL %s: got gnta=%b gntb=%b sel=%b z=%h zv=%b, expected gnta=%b gntb=%b sel=%b z=%h zv=%b",
                     nm, GNTA, GNTB, SEL, Z, ZV, ga, gb, sel, z, zv);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        // single A burst, then pointer check and A/B handover
        vq.push_back(mk(1,0,0,0,8'h11,8'h00, 1,0,1,8'h00,0));
        vq.push_back(mk(1,0,0,0,8'h11,8'h00, 1,0,1,8'h11,1));
        vq.push_back(mk(1,0,0,0,8'h22,8'h00, 1,0,1,8'h22,1));
        vq.push_back(mk(1,0,1,0,8'h33,8'h00, 0,0,1,8'h33,1));
        vq.push_back(mk(0,0,0,0,8'h00,8'h00, 0,0,1,8'h33,0));
        vq.push_back(mk(1,1,0,0,8'h00,8'h00, 0,1,0,8'h33,0));
        vq.push_back(mk(1,1,0,1,8'h00,8'h44, 1,0,1,8'h44,1));
        vq.push_back(mk(1,0,1,0,8'h55,8'h00, 0,0,1,8'h55,1));
        vq.push_back(mk(0,0,0,0,8'h00,8'h00, 0,0,1,8'h55,0));
        // hold limit with B waiting: exactly four A beats
        vq.push_back(mk(1,0,0,0,8'ha1,8'h00, 1,0,1,8'h55,0));
        vq.push_back(mk(1,1,0,0,8'ha2,8'h00, 1,0,1,8'ha2,1));
        vq.push_back(mk(1,1,0,0,8'ha3,8'h00, 1,0,1,8'ha3,1));
        vq.push_back(mk(1,1,0,0,8'ha4,8'h00, 1,0,1,8'ha4,1));
        vq.push_back(mk(1,1,0,0,8'ha5,8'h00, 0,1,0,8'ha5,1));
        vq.push_back(mk(0,1,0,1,8'h00,8'hb1, 0,0,0,8'hb1,1));
        vq.push_back(mk(0,0,0,0,8'h00,8'h00, 0,0,0,8'hb1,0));
        // hold limit with B idle: A keeps the path past the limit
        vq.push_back(mk(1,0,0,0,8'hc0,8'h00, 1,0,1,8'hb1,0));
        for (int k = 1; k <= 11; k++)
            vq.push_back(mk(1,0,0,0,8'(8'hc0 + k),8'h00, 1,0,1,8'(8'hc0 + k),1));
        vq.push_back(mk(1,1,0,0,8'hd0,8'h00, 0,1,0,8'hd0,1));
        vq.push_back(mk(0,1,0,0,8'h00,8'he0, 0,1,0,8'he0,1));
        vq.push_back(mk(0,1,0,1,8'h00,8'he1, 0,0,0,8'he1,1));
        vq.push_back(mk(0,0,0,0,8'h00,8'h00, 0,0,0,8'he1,0));
        // mid-burst abandon
        vq.push_back(mk(1,0,0,0,8'hf0,8'h00, 1,0,1,8'he1,0));
        vq.push_back(mk(1,0,0,0,8'hf1,8'h00, 1,0,1,8'hf1,1));
        vq.push_back(mk(0,0,0,0,8'hf2,8'h00, 0,0,1,8'hf1,0));
        vq.push_back(mk(0,0,0,0,8'h00,8'h00, 0,0,1,8'hf1,0));
        // fairness with single-beat bursts, pointer at B
        vq.push_back(mk(1,1,1,1,8'h10,8'h20, 0,1,0,8'hf1,0));
        for (int k = 1; k <= 6; k++) begin
            if (k % 2 == 1)
                vq.push_back(mk(1,1,1,1,8'(8'h10 + k),8'(8'h20 + k), 1,0,1,8'(8'h20 + k),1));
            else
                vq.push_back(mk(1,1,1,1,8'(8'h10 + k),8'(8'h20 + k), 0,1,0,8'(8'h10 + k),1));
        end

        CD = 1'b1;
        drive(0,0,0,0,8'h00,8'h00);
        #2;
        chk("reset_async", 0,0,0,8'h00,0);
        @(posedge CK);
        #1;
        CD = 1'b0;
        chk("reset_release", 0,0,0,8'h00,0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ra, vq[i].rb, vq[i].la, vq[i].lb, vq[i].da, vq[i].db);
            tick();
            chk($sformatf("vec%0d", i), vq[i].ga, vq[i].gb, vq[i].sel, vq[i].z, vq[i].zv);
        end

        // B owns the path; clear asynchronously mid-burst
        drive(0,1,0,0,8'h00,8'h77);
        tick();
        chk("b_beat", 0,1,0,8'h77,1);
        #3;
        CD = 1'b1;
        #1;
        chk("async_clear", 0,0,0,8'h00,0);
        tick();
        CD = 1'b0;
        chk("clear_held", 0,0,0,8'h00,0);

        // simultaneous first request after clear: A first, then B with no bubble
        drive(1,1,0,0,8'h30,8'h40);
        tick();
        chk("sim_grant_a", 1,0,1,8'h00,0);
        drive(1,1,0,0,8'h31,8'h40);
        tick();
        chk("sim_a_beat", 1,0,1,8'h31,1);
        drive(1,1,1,0,8'h32,8'h40);
        tick();
        chk("sim_swap_b", 0,1,0,8'h32,1);
        drive(0,1,0,1,8'h00,8'h41);
        tick();
        chk("sim_b_beat", 0,0,0,8'h41,1);
        drive(0,0,0,0,8'h00,8'h00);
        tick();
        chk("sim_idle", 0,0,0,8'h41,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
